// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory port, the redirect port and the decode
// valid/ready handshake of the fetch stage.
//   master : the fetch stage (drives request, address, valid, instr, pc)
//   slave  : its environment (instruction memory, branch unit, decode)
// Signals:
//   o_imem_req / o_imem_addr : read request and word address
//   i_imem_data              : read data, valid one cycle after the request
//   i_redirect / i_redirect_pc : PC redirect and its target
//   o_valid / i_ready        : head-of-FIFO handshake toward decode
//   o_instr / o_pc           : head instruction and its address
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_INSTR = 256
);
  localparam int INSTR_SELECT = $clog2(NUM_INSTR);

  logic                    o_imem_req;
  logic [INSTR_SELECT-1:0] o_imem_addr;
  logic [REG_WIDTH-1:0]    i_imem_data;
  logic                    i_redirect;
  logic [INSTR_SELECT-1:0] i_redirect_pc;
  logic                    o_valid;
  logic                    i_ready;
  logic [REG_WIDTH-1:0]    o_instr;
  logic [INSTR_SELECT-1:0] o_pc;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc,
    input  i_imem_data, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc,
    output i_imem_data, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the program counter, issues one-cycle-latency
// reads to instruction memory, buffers returned {instr, pc} pairs in a small
// prefetch FIFO and presents the head to decode over valid/ready. A redirect
// flushes the FIFO, drops any response in flight and restarts fetch at the
// target address.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : fetch_unit_if.master (memory, redirect and decode handshake)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_INSTR  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(NUM_INSTR);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [REG_WIDTH-1:0] instr;
    logic [AW-1:0]        pc;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  entry_t          head;

  logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   req_pc_q,   req_pc_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic            inflight_q, inflight_d;
  logic            kill_q,     kill_d;

  logic            req;
  logic            push;
  logic            pop;
  logic            valid;
  logic [CW:0]     occupancy;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    // Credits use the registered count only: a pop this cycle frees a slot
    // for the next cycle, which keeps a push from ever meeting a full FIFO.
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    req        = !rst && !bus.i_redirect && (occupancy < DEPTH_C);
    push       = inflight_q && !kill_q && !bus.i_redirect;
    valid      = !rst && (count_q != '0);
    pop        = valid && bus.i_ready;

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = req;
    kill_d     = 1'b0;

    if (req) begin
      fetch_pc_d = fetch_pc_q + AW'(1);  // wraps mod NUM_INSTR (power of two)
      req_pc_d   = fetch_pc_q;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Redirect overrides everything: flush, retarget, and mark any response
    // still in flight as dead.
    if (bus.i_redirect) begin
      fetch_pc_d = bus.i_redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      kill_d     = inflight_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      // NOTE: the buffer storage is cleared as well, so nothing fetched
      // before reset can ever be observed afterwards; this keeps it in flops.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      if (push) fifo_q[wr_ptr_q] <= '{instr: bus.i_imem_data, pc: req_pc_q};
    end
  end

  // Outputs come only from the FIFO head; there is no bypass from memory.
  always_comb begin
    head = fifo_q[rd_ptr_q];
    if (rst) head = '0;
  end

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fetch_pc_q;
  assign bus.o_valid     = valid;
  assign bus.o_instr     = head.instr;
  assign bus.o_pc        = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A 256-entry instance carries the main
// directed and random sequences against a stream-level reference model; a
// 16-entry instance checks address wrap-around after a redirect.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  fetch_unit_if #(.REG_WIDTH(32), .NUM_INSTR(256)) a_if ();
  fetch_unit_if #(.REG_WIDTH(32), .NUM_INSTR(16))  w_if ();

  fetch_unit #(.REG_WIDTH(32), .NUM_INSTR(256), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.master)
  );

  fetch_unit #(.REG_WIDTH(32), .NUM_INSTR(16), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (w_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memories: word k holds 0x100 + k, read latency one cycle.
  // Without a request the data bus carries garbage.
  always @(posedge clk) begin
    a_if.i_imem_data <= a_if.o_imem_req ? 32'h100 + 32'(a_if.o_imem_addr) : 32'hDEAD_BEEF;
    w_if.i_imem_data <= w_if.o_imem_req ? 32'h100 + 32'(w_if.o_imem_addr) : 32'hDEAD_BEEF;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Stream-level reference model for dut_a.
  int         issued;     // requests issued since the last flush
  int         delivered;  // instructions accepted by decode since the flush
  int         infl_m;     // 1 if a request was issued in the previous cycle
  logic [7:0] exp_pc;     // next pc decode should see
  logic [7:0] exp_req;    // next address fetch should request

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on dut_a: drive inputs, check at the falling edge,
  // advance the model, then move past the rising edge.
  task automatic step(input logic r, input logic ready, input logic redir, input logic [7:0] tgt);
    logic req_exp;
    logic valid_exp;
    rst                = r;
    a_if.i_ready       = ready;
    a_if.i_redirect    = redir;
    a_if.i_redirect_pc = tgt;
    @(negedge clk);
    if (r) begin
      check("rst_req",   32'(a_if.o_imem_req), 32'd0);
      check("rst_valid", 32'(a_if.o_valid),    32'd0);
      check("rst_pc",    32'(a_if.o_pc),       32'd0);
      check("rst_instr", a_if.o_instr,         32'd0);
      issued = 0; delivered = 0; infl_m = 0; exp_pc = '0; exp_req = '0;
    end else begin
      req_exp   = !redir && ((issued - delivered) < DEPTH);
      valid_exp = (issued - infl_m - delivered) > 0;
      check("req", 32'(a_if.o_imem_req), 32'(req_exp));
      if (a_if.o_imem_req && req_exp) check("req_addr", 32'(a_if.o_imem_addr), 32'(exp_req));
      check("valid", 32'(a_if.o_valid), 32'(valid_exp));
      if (valid_exp) begin
        check("head_pc",    32'(a_if.o_pc), 32'(exp_pc));
        check("head_instr", a_if.o_instr,   32'h100 + 32'(exp_pc));
      end
      if (redir) begin
        issued = 0; delivered = 0; infl_m = 0; exp_pc = tgt; exp_req = tgt;
      end else begin
        if (valid_exp && ready) begin
          delivered++;
          exp_pc = exp_pc + 8'd1;
        end
        infl_m = req_exp ? 1 : 0;
        if (req_exp) begin
          issued++;
          exp_req = exp_req + 8'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    int first_at;
    logic [3:0] w_exp;

    rst                = 1'b1;
    a_if.i_ready       = 1'b0;
    a_if.i_redirect    = 1'b0;
    a_if.i_redirect_pc = '0;
    w_if.i_ready       = 1'b1;
    w_if.i_redirect    = 1'b0;
    w_if.i_redirect_pc = '0;
    issued = 0; delivered = 0; infl_m = 0; exp_pc = '0; exp_req = '0;
    @(posedge clk);
    #1;

    // Reset, then start-up stream with decode always ready.
    repeat (3)  step(1'b1, 1'b1, 1'b0, 8'd0);
    repeat (14) step(1'b0, 1'b1, 1'b0, 8'd0);

    // Back-pressure: FIFO fills, requests stop, head holds; then drain.
    repeat (10) step(1'b0, 1'b0, 1'b0, 8'd0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 8'd0);

    // Redirect with buffered and in-flight instructions.
    repeat (3)  step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    repeat (6)  step(1'b0, 1'b1, 1'b0, 8'd0);

    // Back-to-back redirects: the second target wins.
    step(1'b0, 1'b1, 1'b1, 8'd5);
    step(1'b0, 1'b1, 1'b1, 8'd9);
    repeat (8)  step(1'b0, 1'b1, 1'b0, 8'd0);

    // Reset while three entries are buffered, then restart from pc 0.
    step(1'b0, 1'b0, 1'b1, 8'h20);
    repeat (4)  step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 8'd0);

    // Random decode stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      step(1'b0, $urandom_range(3) != 0, $urandom_range(15) == 0, 8'($urandom));
    end
    repeat (6) step(1'b0, 1'b1, 1'b0, 8'd0);

    // Wrap-around on the 16-entry instance: redirect to 14.
    w_if.i_redirect    = 1'b1;
    w_if.i_redirect_pc = 4'd14;
    @(posedge clk);
    #1;
    w_if.i_redirect = 1'b0;
    got      = 0;
    first_at = -1;
    for (int i = 0; i < 20 && got < 4; i++) begin
      @(negedge clk);
      if (w_if.o_valid) begin
        if (got == 0) first_at = i;
        w_exp = 4'(14 + got);
        check("wrap_pc",    32'(w_if.o_pc), 32'(w_exp));
        check("wrap_instr", w_if.o_instr,   32'h100 + 32'(w_exp));
        got++;
      end
      @(posedge clk);
      #1;
    end
    check("wrap_latency", 32'(first_at), 32'd2);
    check("wrap_count",   32'(got),      32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the pipelined core. It sits directly upstream of the opcode decoder (`opd_32`) and drives the instruction memory. It owns the program counter and a small prefetch FIFO, and delivers instruction/PC pairs to decode over a valid/ready handshake. Branch and compare resolution steers the PC through a redirect port that flushes everything the stage has already fetched.

## Interface
- `REG_WIDTH`, default 32: instruction word width.
- `NUM_INSTR`, default 256: instruction memory depth. Must be a power of two. `INSTR_SELECT = $clog2(NUM_INSTR)`.
- `FIFO_DEPTH`, default 4: number of prefetch buffer entries. Must be a power of two and ≥ 2.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `o_imem_req` output 1: read request to instruction memory this cycle.
- `o_imem_addr` output INSTR_SELECT: word address of the request.
- `i_imem_data` input REG_WIDTH: read data. Valid exactly one cycle after the request.
- `i_redirect` input 1: PC redirect from branch resolution.
- `i_redirect_pc` input INSTR_SELECT: redirect target.
- `o_valid` output 1: FIFO head holds a valid instruction.
- `i_ready` input 1: decode accepts the head this cycle.
- `o_instr` output REG_WIDTH: head instruction.
- `o_pc` output INSTR_SELECT: address of the head instruction.

## Operation
**State**
- `fetch_pc`: address of the next request.
- FIFO storage of {instr, pc} pairs, with read pointer, write pointer and `count`.
- `inflight` bit: a request was issued last cycle.
- `kill` bit: drop the response returning this cycle.

**Request issue**
- `o_imem_req = !rst && !i_redirect && (count + inflight < FIFO_DEPTH)`.
- `count` is the registered value. A pop in the same cycle does not earn a credit.
- `o_imem_addr = fetch_pc`.
- On issue: `fetch_pc <= fetch_pc + 1`, wrapping mod `NUM_INSTR` (NUM_INSTR-1 → 0). The PC of the issued request is carried alongside it in a register.

**Response**
- When `inflight && !kill && !i_redirect`: push {`i_imem_data`, carried pc} into the FIFO.
- The credit rule guarantees the FIFO is never full when a push occurs. Overflow is impossible by construction.

**Pop**
- A pop happens when `o_valid && i_ready`: the read pointer advances.
- Simultaneous push and pop leaves `count` unchanged.

**Outputs**
- `o_valid = (count != 0)`.
- `o_instr` and `o_pc` are taken from the FIFO head. No bypass from `i_imem_data`.

**Redirect** (highest priority, takes effect in the cycle it is asserted)
- FIFO is cleared: pointers and `count` go to 0.
- `fetch_pc <= i_redirect_pc`.
- No request is issued that cycle.
- `kill <= inflight`, so a response to a request issued in the redirect cycle is impossible, and any response already in flight is dropped.
- A handshake (`o_valid && i_ready`) in the redirect cycle counts as accepted by decode. Discarding that instruction is decode's responsibility.

**No-op cases**
- Back-to-back redirects: the last one wins, with no stale output between them.
- `i_ready` while `!o_valid` has no effect.

## Timing
- **Reset:** while `rst` is high, `o_imem_req=0`, `o_valid=0`, `o_pc=0`, `o_instr=0`. `fetch_pc`, pointers, `count`, `inflight` and `kill` all go to 0, and all storage is cleared to 0.
- **Reset mid-operation:** all buffered and in-flight instructions are lost. The stage then behaves exactly as after power-up reset.
- **Start after reset:** in the first cycle after `rst` falls, the request for address 0 is issued. Data returns the next cycle, and `o_valid` with `o_pc=0` rises 2 cycles after the deassertion edge.
- **Redirect latency:** with a redirect in cycle r, the request for the target is issued in r+1. `o_valid` with `o_pc=i_redirect_pc` is seen in r+3. `o_valid` is 0 in r+1 and r+2.
- **Throughput:** one instruction per cycle sustained when `i_ready` is held at 1 and `FIFO_DEPTH ≥ 3`.
- **Back-pressure:** with `i_ready=0`, the FIFO fills to `FIFO_DEPTH` and `o_imem_req` falls. `o_instr` and `o_pc` stay stable while `o_valid && !i_ready`.

## Test plan
- **Start-up stream.** Memory word k = 0x100+k, `i_ready=1`, release reset. Expect `o_valid` 2 cycles after release, then `o_pc`=0,1,2,… with `o_instr`=0x100,0x101,… every cycle, with no gaps.
- **Back-pressure.** Hold `i_ready=0` for 10 cycles, then set it to 1. Expect exactly 4 pushes, `o_imem_req`=0 while full, and the head held at pc 0. After release, expect pcs 0..N in order with no duplicates and no gaps.
- **Redirect while full and in flight.** Redirect to 0x40 in cycle r. Expect `o_valid`=0 in r+1 and r+2. In r+3 expect `o_pc`=0x40 and `o_instr`=0x140. No pre-redirect instruction may appear.
- **Wrap-around.** `NUM_INSTR=16`, redirect to 14. Expect delivered pcs 14, 15, 0, 1 with the matching data.
- **Back-to-back redirects.** Redirect to 5 in cycle r and to 9 in r+1. Expect first valid `o_pc`=9 at r+4, and pc 5 never delivered.
- **Reset mid-stream.** Assert `rst` for 1 cycle while the FIFO holds 3 entries. Expect `o_valid`=0 during and after reset until 2 cycles after release, then the stream restarts at `o_pc`=0.
